// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Elastic ready/valid pipeline stage with a 2-entry skid buffer. The stage
// carries LANES words of DATA_W bits. in_ready comes straight from a flop,
// so there is no combinational path from out_ready back upstream. The extra
// (skid) entry catches the bundle that upstream sends in the cycle before it
// sees in_ready fall.
//
// Ports:
//   Clk           clock; all state changes on the rising edge
//   Rst           synchronous active-high reset; highest priority
//   flush         synchronous bubble insert; empties the stage
//   in_valid      upstream offers a bundle
//   in_ready      stage can take a bundle (registered)
//   in_data       upstream bundle; lane k at [k*DATA_W +: DATA_W]
//   out_valid     out_data holds a valid bundle
//   out_ready     downstream takes the bundle this cycle
//   out_data      bundle presented downstream (the main register)
//   occupancy     number of entries held: 0, 1 or 2
//   stall_cycles  saturating count of cycles with out_valid=1, out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [1:0]                occupancy,
    output logic [CNT_W-1:0]          stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               in_ready_reg;
    logic [CNT_W-1:0]   stall_reg;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic clear_data;

    assign out_valid    = (state_reg != ST_EMPTY);
    assign in_ready     = in_ready_reg;
    assign stall_cycles = stall_reg;
    assign accept       = in_valid & in_ready_reg;
    assign drain        = out_valid & out_ready;
    assign clear_data   = Rst | flush;

    always_comb begin
        occupancy = 2'd0;
        case (state_reg)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and data-path load selects.
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next   = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next = ST_FULL;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so accept cannot be set.
                if (drain) begin
                    state_next     = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // A same-cycle accept is dropped; a same-cycle drain has already
        // completed from the downstream point of view.
        if (clear_data) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
            stall_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            // Registering the next-state view keeps in_ready exact while
            // avoiding any path from out_ready.
            in_ready_reg <= (state_next != ST_FULL);
            // A flush cycle still counts when the stall condition holds.
            if (out_valid && !out_ready && (stall_reg != {CNT_W{1'b1}})) begin
                stall_reg <= stall_reg + CNT_W'(1);
            end
        end
    end

    // Per-lane storage: main register drives out_data, skid holds the
    // second bundle while the stage is full.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] main_reg;
        logic [DATA_W-1:0] skid_reg;

        always_ff @(posedge Clk) begin
            if (clear_data) begin
                main_reg <= '0;
                skid_reg <= '0;
            end else begin
                if (load_main_in) begin
                    main_reg <= in_data[gi*DATA_W +: DATA_W];
                end else if (load_main_skid) begin
                    main_reg <= skid_reg;
                end
                if (load_skid) begin
                    skid_reg <= in_data[gi*DATA_W +: DATA_W];
                end
            end
        end

        assign out_data[gi*DATA_W +: DATA_W] = main_reg;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Drives pipe_stage_skid (DATA_W=8, LANES=3, CNT_W=4) with directed
// scenarios and randomized traffic. A queue-based reference model with a
// capacity of two bundles predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DATA_W = 8;
    localparam int LANES  = 3;
    localparam int CNT_W  = 4;
    localparam int W      = DATA_W * LANES;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cycles;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of at most two bundles.
    logic [W-1:0] q[$];
    logic [W-1:0] hold_val;
    int           cnt_m;
    bit           ready_m;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r,
                        input bit f, input bit rs);
        bit acc;
        bit drn;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        Rst       = rs;

        acc = v && ready_m;
        drn = (q.size() > 0) && r;
        if (rs) begin
            q.delete();
            hold_val = '0;
            cnt_m    = 0;
        end else begin
            if ((q.size() > 0) && !r && (cnt_m < SAT)) cnt_m++;
            if (f) begin
                q.delete();
                hold_val = '0;
            end else begin
                if (drn) begin
                    hold_val = q[0];
                    void'(q.pop_front());
                end
                if (acc) q.push_back(d);
                if (q.size() > 0) hold_val = q[0];
            end
        end
        ready_m = (q.size() < 2);

        @(posedge Clk);
        @(negedge Clk);

        $display("cyc v=%0b d=%06h r=%0b f=%0b rst=%0b -> ov=%0b od=%06h ir=%0b occ=%0d st=%0d",
                 v, d, r, f, rs, out_valid, out_data, in_ready, occupancy, stall_cycles);
        check_val("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check_val("in_ready", 64'(in_ready), 64'(ready_m));
        check_val("occupancy", 64'(occupancy), 64'(q.size()));
        check_val("out_data", 64'(out_data), 64'((q.size() > 0) ? q[0] : hold_val));
        check_val("stall_cycles", 64'(stall_cycles), 64'(cnt_m));
    endtask

    initial begin
        ready_m  = 1'b1;
        hold_val = '0;
        cnt_m    = 0;
        Rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset state
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);

        // Streaming: lane0 = 1..10, downstream always ready
        for (int i = 1; i <= 10; i++) step(1, W'(i), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        check_val("stream_stall", 64'(stall_cycles), 64'(0));

        // Backpressure / skid: A, B accepted, C offered during stall
        step(1, 24'h00000A, 0, 0, 0);
        step(1, 24'h00000B, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 24'h00000C, 0, 0, 0);
        check_val("bp_data", 64'(out_data), 64'h0A);
        for (int i = 0; i < 4; i++) step(1, 24'h00000C, 1, 0, 0);
        step(0, '0, 1, 0, 0);

        // Flush collision while full
        step(1, 24'h000011, 0, 0, 0);
        step(1, 24'h000022, 0, 0, 0);
        step(1, 24'h000033, 0, 1, 0);
        check_val("flush_data", 64'(out_data), 64'h0);
        step(0, '0, 1, 0, 0);

        // Reset mid-operation, then one bundle with one-cycle latency
        step(1, 24'h000055, 0, 0, 0);
        step(1, 24'h000066, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        check_val("rst_stall", 64'(stall_cycles), 64'(0));
        step(1, 24'h000044, 1, 0, 0);
        check_val("latency", 64'(out_data), 64'h44);

        // Lane order preserved
        step(1, 24'hCCBBAA, 1, 0, 0);
        check_val("lane0", 64'(out_data[7:0]), 64'hAA);
        check_val("lane2", 64'(out_data[23:16]), 64'hCC);
        step(0, '0, 1, 0, 0);

        // Counter saturation
        step(0, '0, 0, 0, 1);
        step(1, 24'h123456, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
        check_val("saturate", 64'(stall_cycles), 64'(SAT));
        step(0, '0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
